// File: rtl/intr_claim_arb_pkg.sv
// Shared types and helpers for the interrupt claim arbiter: gateway state
// encoding, the "no interrupt" ID and per-source priority extraction.
package intr_claim_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } gw_state_e;

  localparam int unsigned IdNone = 0;

  // Upper bounds for the packed priority vector accepted by prio_at().
  localparam int unsigned MaxSrc   = 64;
  localparam int unsigned MaxPrioW = 8;
  localparam int unsigned PrioVecW = MaxSrc * MaxPrioW;

  // Returns the w-bit priority field of source idx from a packed vector.
  function automatic logic [MaxPrioW-1:0] prio_at(input logic [PrioVecW-1:0] vec,
                                                  input int unsigned         idx,
                                                  input int unsigned         w);
    logic [MaxPrioW-1:0] mask;
    mask = MaxPrioW'((1 << w) - 1);
    return MaxPrioW'(vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/intr_gateway.sv
// Per-source interrupt gateway: latches a level request until it is claimed,
// then holds it in service until the matching complete arrives.
module intr_gateway
  import intr_claim_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      intr_i,
  input  logic      claim_hit_i,
  input  logic      complete_hit_i,
  output gw_state_e state_o
);

  gw_state_e state_q, state_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (intr_i)         state_d = PENDING;
      PENDING:    if (claim_hit_i)    state_d = IN_SERVICE;
      IN_SERVICE: if (complete_hit_i) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/intr_claim_arb.sv
// Interrupt target controller: NumSrc gateways, priority/threshold arbitration
// with round-robin tie-breaking, and a claim/complete retirement handshake.
module intr_claim_arb
  import intr_claim_arb_pkg::*;
#(
  parameter int unsigned NumSrc = 8,
  parameter int unsigned PrioW  = 2,
  parameter int unsigned IdW    = $clog2(NumSrc + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSrc-1:0]       intr_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_i,
  input  logic                    complete_i,
  input  logic [IdW-1:0]          complete_id_i,
  output logic                    irq_o,
  output logic [IdW-1:0]          irq_id_o,
  output logic [NumSrc-1:0]       ip_o,
  output logic                    err_o
);

  localparam int unsigned SelW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  gw_state_e         gw_state [NumSrc];
  logic [PrioW-1:0]  prio     [NumSrc];
  logic [PrioVecW-1:0] prio_ext;

  logic [NumSrc-1:0] pending, eligible, claim_hit, complete_hit;
  logic              claim_valid, complete_err;
  logic [IdW-1:0]    irq_id_q, irq_id_d, rr_ptr_q, rr_ptr_d;
  logic              irq_q, irq_d, err_q, err_d;

  logic [PrioW-1:0]  best_prio;
  int unsigned       pos;
  logic [SelW-1:0]   sel;

  assign prio_ext = PrioVecW'(prio_i);

  for (genvar k = 0; k < NumSrc; k++) begin : g_src
    assign prio[k] = PrioW'(prio_at(prio_ext, k, PrioW));

    intr_gateway u_gw (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .intr_i         (intr_i[k]),
      .claim_hit_i    (claim_hit[k]),
      .complete_hit_i (complete_hit[k]),
      .state_o        (gw_state[k])
    );
  end

  // Claim acts on the registered winner; a claimed source is masked from the
  // same-cycle arbitration so it can never reappear on irq_id_o.
  always_comb begin
    claim_valid = claim_i && (irq_id_q != IdW'(IdNone));
    for (int unsigned k = 0; k < NumSrc; k++) begin
      pending[k]      = (gw_state[k] == PENDING);
      claim_hit[k]    = claim_valid && (irq_id_q == IdW'(k + 1));
      complete_hit[k] = complete_i && (complete_id_i == IdW'(k + 1)) &&
                        (gw_state[k] == IN_SERVICE);
      eligible[k]     = pending[k] && (prio[k] > threshold_i) && !claim_hit[k];
    end
    complete_err = complete_i && (complete_hit == '0);
    err_d        = err_q | complete_err;
    rr_ptr_d     = claim_valid ? irq_id_q : rr_ptr_q;
  end

  // Scan in round-robin order starting just above rr_ptr_d; a strictly higher
  // priority replaces the current best, so the first of equals wins the tie.
  always_comb begin
    irq_id_d  = '0;
    irq_d     = 1'b0;
    best_prio = '0;
    pos       = 0;
    sel       = '0;
    for (int unsigned off = 0; off < NumSrc; off++) begin
      pos = 32'(rr_ptr_d) + off;
      if (pos >= NumSrc) pos = pos - NumSrc;
      sel = SelW'(pos);
      if (eligible[sel] && (!irq_d || (prio[sel] > best_prio))) begin
        irq_d     = 1'b1;
        best_prio = prio[sel];
        irq_id_d  = IdW'(pos + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_id_q <= '0;
      irq_q    <= 1'b0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      irq_id_q <= irq_id_d;
      irq_q    <= irq_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;
  assign ip_o     = pending;
  assign err_o    = err_q;

endmodule

// File: tb/tb_intr_claim_arb.sv
// Self-checking bench for intr_claim_arb: directed scenarios with literal
// expectations plus a randomized run compared each cycle against a model.
module tb_intr_claim_arb;

  localparam int N  = 8;
  localparam int PW = 2;
  localparam int IW = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic [N-1:0]  intr     = '0;
  logic [N*PW-1:0] prio   = '0;
  logic [PW-1:0] thr      = '0;
  logic          claim    = 1'b0;
  logic          complete = 1'b0;
  logic [IW-1:0] cid      = '0;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  ip;
  logic          err;

  int n_vec  = 0;
  int n_miss = 0;

  intr_claim_arb #(.NumSrc(N), .PrioW(PW), .IdW(IW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .intr_i        (intr),
    .prio_i        (prio),
    .threshold_i   (thr),
    .claim_i       (claim),
    .complete_i    (complete),
    .complete_id_i (cid),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .ip_o          (ip),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  // Model state: per-source 0=idle, 1=pending, 2=in service.
  int m_st [N] = '{default: 0};
  int m_id  = 0;
  int m_ptr = 0;
  bit m_err = 1'b0;

  function automatic int m_prio(int k);
    return int'(prio[k*PW +: PW]);
  endfunction

  function automatic bit m_elig(int id, int claimed);
    return (m_st[id-1] == 1) && (m_prio(id-1) > int'(thr)) && (id != claimed);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_st[k] = 0;
      m_id  = 0;
      m_ptr = 0;
      m_err = 1'b0;
    end else begin : step
      int claimed, ptr, best, winner, c, id;
      bit legal;
      claimed = (claim && m_id != 0) ? m_id : 0;
      ptr     = (claimed != 0) ? claimed : m_ptr;
      c       = int'(cid);
      legal   = complete && c >= 1 && c <= N && m_st[(c >= 1 && c <= N) ? c-1 : 0] == 2;
      if (complete && !legal) m_err = 1'b1;
      best = -1;
      for (int i = 1; i <= N; i++)
        if (m_elig(i, claimed) && m_prio(i-1) > best) best = m_prio(i-1);
      winner = 0;
      if (best >= 0) begin
        for (int s = 1; s <= N; s++) begin
          id = (ptr + s - 1) % N + 1;
          if (winner == 0 && m_elig(id, claimed) && m_prio(id-1) == best) winner = id;
        end
      end
      for (int k = 0; k < N; k++) begin
        case (m_st[k])
          0: if (intr[k]) m_st[k] = 1;
          1: if (claimed == k + 1) m_st[k] = 2;
          default: if (legal && c == k + 1) m_st[k] = 0;
        endcase
      end
      m_id  = winner;
      m_ptr = ptr;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [31:0] exp_ip;
    exp_ip = '0;
    for (int k = 0; k < N; k++) if (m_st[k] == 1) exp_ip[k] = 1'b1;
    check("m_irq_id", 32'(irq_id), 32'(m_id));
    check("m_irq",    32'(irq),    32'(m_id != 0));
    check("m_ip",     32'(ip),     exp_ip);
    check("m_err",    32'(err),    32'(m_err));
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_claim();
    claim = 1'b1;
    tick(1);
    claim = 1'b0;
  endtask

  task automatic pulse_complete(int id);
    complete = 1'b1;
    cid      = IW'(id);
    tick(1);
    complete = 1'b0;
    cid      = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    intr  = '0;
    prio  = '0;
    thr   = '0;
    claim = 1'b0;
    complete = 1'b0;
    cid   = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    // Initial reset and its literal outputs.
    #2 rst_n = 1'b0;
    #1;
    check("rst_irq", 32'(irq), 0);
    check("rst_id",  32'(irq_id), 0);
    check("rst_ip",  32'(ip), 0);
    check("rst_err", 32'(err), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1);

    // Single source: two cycles from line to irq.
    prio = 16'h0020;
    intr = 8'h04;
    tick(1);
    check("t1_ip_early", 32'(ip), 32'h04);
    check("t1_id_early", 32'(irq_id), 0);
    tick(1);
    check("t1_id",  32'(irq_id), 3);
    check("t1_irq", 32'(irq), 1);

    // Round-robin tie between IDs 1 and 5.
    do_reset();
    prio = 16'h0101;
    intr = 8'h11;
    tick(2);
    check("t2_id_first", 32'(irq_id), 1);
    check("t2_ip",       32'(ip), 32'h11);
    pulse_claim();
    check("t2_id_after_claim", 32'(irq_id), 5);
    pulse_complete(1);
    tick(1);
    check("t2_ip_repend", 32'(ip), 32'h11);
    check("t2_id_hold",   32'(irq_id), 5);
    pulse_claim();
    check("t2_id_rr", 32'(irq_id), 1);

    // Priority and threshold.
    do_reset();
    prio = 16'h00C1;
    intr = 8'h09;
    tick(2);
    check("t3_id_prio", 32'(irq_id), 4);
    thr = 2'd3;
    tick(1);
    check("t3_irq_thr", 32'(irq), 0);
    check("t3_ip_thr",  32'(ip), 32'h09);
    thr = 2'd0;
    tick(1);
    check("t3_id_back", 32'(irq_id), 4);

    // Level held through service, then illegal completes.
    do_reset();
    prio = 16'h0004;
    intr = 8'h02;
    tick(2);
    check("t4_id", 32'(irq_id), 2);
    pulse_claim();
    check("t4_ip_svc", 32'(ip), 0);
    check("t4_id_svc", 32'(irq_id), 0);
    pulse_complete(2);
    check("t4_ip_idle", 32'(ip), 0);
    tick(1);
    check("t4_ip_repend", 32'(ip), 32'h02);
    check("t5_err_clear", 32'(err), 0);
    pulse_complete(6);
    check("t5_err_set", 32'(err), 1);
    check("t5_ip_same", 32'(ip), 32'h02);
    pulse_complete(0);
    tick(2);
    check("t5_err_sticky", 32'(err), 1);

    // Asynchronous reset mid-service.
    do_reset();
    prio = 16'h5555;
    intr = 8'h07;
    tick(2);
    check("t6_id1", 32'(irq_id), 1);
    pulse_claim();
    check("t6_id2", 32'(irq_id), 2);
    pulse_claim();
    check("t6_id3", 32'(irq_id), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_irq", 32'(irq), 0);
    check("t6_async_id",  32'(irq_id), 0);
    check("t6_async_ip",  32'(ip), 0);
    #3 rst_n = 1'b1;
    tick(1);
    check("t6_ip_repend", 32'(ip), 32'h07);
    tick(1);
    check("t6_id_restart", 32'(irq_id), 1);

    // Randomized traffic against the model.
    do_reset();
    prio = 16'h9E4B;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int q[$];
      if ($urandom_range(0, 3) == 0) intr = N'($urandom);
      if ($urandom_range(0, 31) == 0) prio = 16'($urandom);
      if ($urandom_range(0, 31) == 0) thr = PW'($urandom_range(0, 2));
      claim    = ($urandom_range(0, 3) == 0);
      complete = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) if (m_st[k] == 2) q.push_back(k + 1);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cid = IW'(q[$urandom_range(0, q.size() - 1)]);
      else
        cid = IW'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) begin
        complete = 1'b1;
        cid      = IW'(m_id);
      end
      if (cyc % 1000 == 999) begin
        claim    = 1'b0;
        complete = 1'b0;
        do_reset();
      end else begin
        tick(1);
      end
    end
    claim    = 1'b0;
    complete = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/intr_claim_arb.md
Name: intr_claim_arb

Overview:
Interrupt target controller sitting between the per-peripheral interrupt register blocks and a core's external-interrupt input. It collects NumSrc level interrupt lines and gates each through a pending/in-service gateway. It selects the highest-priority eligible source above a threshold, with round-robin tie-breaking, and presents that source to the core. Sources are retired through a claim/complete handshake.

Parameters:
NumSrc, 8, number of interrupt sources; IDs are 1..NumSrc, and ID 0 means "none".
PrioW, 2, priority field width; priority 0 never interrupts.
IdW, $clog2(NumSrc+1), width of an ID field.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
intr_i  input  NumSrc  level interrupt lines; bit k is source ID k+1
prio_i  input  NumSrc*PrioW  per-source priority; source k uses bits [k*PrioW +: PrioW]
threshold_i  input  PrioW  a source is eligible only if prio > threshold_i (strict)
claim_i  input  1  single-cycle pulse; core claims the ID currently on irq_id_o
complete_i  input  1  single-cycle pulse; core signals end of service
complete_id_i  input  IdW  ID being completed
irq_o  output  1  interrupt request to the core (registered)
irq_id_o  output  IdW  winning ID, or 0 (registered)
ip_o  output  NumSrc  pending vector (gateway PENDING state)
err_o  output  1  sticky; set by an illegal complete

Behaviour:
- One clock domain (clk_i). Reset is asynchronous and active-low (rst_ni). On reset: all gateways go to IDLE, the round-robin pointer is 0, and irq_o, irq_id_o, ip_o and err_o are all 0.
- Per-source gateway FSM, states IDLE, PENDING and IN_SERVICE:
  - IDLE -> PENDING when intr_i[k]=1.
  - PENDING -> IN_SERVICE on a claim of ID k+1. There is no PENDING -> IDLE path: the request is latched even if intr_i drops.
  - IN_SERVICE -> IDLE on complete_i with complete_id_i=k+1.
  - intr_i is ignored while the source is PENDING or IN_SERVICE. If the line is still high after complete, the gateway re-pends one cycle later (IDLE, then PENDING).
- Eligibility: eligible[k] = PENDING[k] AND prio[k] > threshold_i. During a claim_i cycle, the source currently on irq_id_o is also masked out.
- Arbitration:
  - Winner is the highest prio among eligible sources.
  - Ties are broken round-robin: the search starts at the ID just above the last claimed ID, wraps from NumSrc to 1, and starts at 1 after reset.
  - irq_id_o and irq_o are flopped from the combinational winner, giving one cycle of latency from gateway state to outputs. irq_o = (irq_id_o != 0).
- Claim:
  - Acts on the registered irq_id_o at that edge: the gateway moves to IN_SERVICE and the RR pointer is set to that ID.
  - claim_i while irq_id_o=0 is a no-op.
  - Because of the masking above, the cycle after a claim shows the next winner or 0, never the claimed ID again.
- Complete:
  - An ID that is not IN_SERVICE (including 0 and IDs > NumSrc) is ignored and sets err_o.
  - err_o clears only on reset.
- Simultaneous events:
  - A claim of ID a and a complete of ID b≠a in the same cycle are both honoured.
  - A complete of a and a claim of a in the same cycle cannot be legal, because a is not yet IN_SERVICE. The claim is honoured, the complete is flagged in err_o, and the gateway ends in IN_SERVICE.
- Threshold or priority changes take effect at the next arbitration, so irq_o may drop without a claim and the source stays PENDING.
- Multiple sources may be IN_SERVICE concurrently (nested service).
- Reset asserted mid-operation clears all state immediately, independent of the clock.

Decomposition:
- Package intr_claim_arb_pkg holds the gateway state enum (IDLE=2'd0, PENDING=2'd1, IN_SERVICE=2'd2), the ID 0 "none" constant, and a helper function for priority slicing.
- Sub-module intr_gateway is instantiated NumSrc times. It contains the 3-state FSM with inputs intr, claim_hit and complete_hit, and output state.
- The arbiter (priority max plus RR rotate) and the output flops live in the top module.

Test Plan:
1. Reset, then intr_i=8'h04 with prio[2]=2 and threshold 0 -> irq_id_o=3 and irq_o=1 two cycles after intr_i rises (gateway edge plus output flop); ip_o=8'h04.
2. Tie breaking:
   - Setup: intr_i=8'h11 with prio 1 for both and threshold 0.
   - Expected: IDs 1 and 5 both pending, irq_id_o=1.
   - Claim -> the next cycle shows irq_id_o=5, never 1.
   - Complete 1 with line 1 still high, then claim 5 -> the next winner is 1, following the RR order after 5.
3. Priority and threshold:
   - Setup: prio[0]=1 and prio[3]=3, both pending.
   - Expected: irq_id_o=4.
   - Set threshold_i=3 -> irq_o drops next cycle and ip_o is unchanged.
   - Set threshold_i=0 -> ID 4 returns.
4. Level hold: claim ID 2 with intr_i[1] held high -> ip_o[1]=0 during service; after complete_id=2, ip_o[1]=1 one cycle later.
5. Illegal complete:
   - complete_id=6 while source 6 is IDLE -> err_o=1 (sticky) and no state change.
   - complete_id=0 -> err_o stays 1.
6. Reset mid-service: with two sources IN_SERVICE and one PENDING, pulse rst_ni low asynchronously (off a clock edge) -> all outputs 0 immediately; after release with lines high, re-pending starts from ID 1 round-robin.
